// File: rtl/shared_ram_arbiter_pkg.sv
// Shared work-RAM arbiter: common types and constants.
package shared_ram_arbiter_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RELEASE,
    GAP
  } state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

endpackage

// File: rtl/shared_ram_port.sv
// Per-CPU port: latched read data and combinational WAIT generation.
module shared_ram_port #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_i,
  input  logic          grant_i,
  input  logic          release_i,
  input  logic          load_i,
  input  logic [DW-1:0] rdata_i,
  output logic [DW-1:0] dout_o,
  output logic          wait_n_o
);

  logic [DW-1:0] dout_q;

  // Read data latch: updated only on the final access edge of a read by this port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
    end else if (load_i) begin
      dout_q <= rdata_i;
    end
  end

  // WAIT is held low for any request except while this port owns the RAM in RELEASE.
  always_comb begin
    wait_n_o = !(req_i && !(grant_i && release_i));
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/shared_ram_arbiter.sv
// Two-port shared RAM arbiter driving the 74244 bank enables and RAM strobes.
module shared_ram_arbiter
  import shared_ram_arbiter_pkg::*;
#(
  parameter int unsigned AW         = 11,
  parameter int unsigned DW         = 8,
  parameter int unsigned ACCESS_CYC = 2,
  parameter int unsigned TURN_CYC   = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_wr,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic [DW-1:0] a_dout,
  output logic          a_wait_n,
  input  logic          b_req,
  input  logic          b_wr,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic [DW-1:0] b_dout,
  output logic          b_wait_n,
  output logic          ga_n,
  output logic          gb_n,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          ram_oe_n,
  output logic          ram_we_n
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              ga_n_q, ga_n_d;
  logic              gb_n_q, gb_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  owner_e            pick;
  logic              load_rd;

  // State, owner, counter and all buffer/strobe registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_A;
      last_q  <= OWN_B;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      ga_n_q  <= 1'b1;
      gb_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      ga_n_q  <= ga_n_d;
      gb_n_q  <= gb_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic; enables are decoded from a single owner bit so they can never both be low.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    ga_n_d  = ga_n_q;
    gb_n_d  = gb_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pick    = OWN_A;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          if (a_req && b_req) begin
            pick = (last_q == OWN_B) ? OWN_A : OWN_B;
          end else if (a_req) begin
            pick = OWN_A;
          end else begin
            pick = OWN_B;
          end
          owner_d = pick;
          ga_n_d  = (pick != OWN_A);
          gb_n_d  = (pick != OWN_B);
          addr_d  = (pick == OWN_A) ? a_addr : b_addr;
          wdata_d = (pick == OWN_A) ? a_din : b_din;
          wr_d    = (pick == OWN_A) ? a_wr : b_wr;
          state_d = SETUP;
        end
      end
      SETUP: begin
        oe_n_d  = wr_q;
        we_n_d  = !wr_q;
        cnt_d   = CNT_W'(ACCESS_CYC - 1);
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!((owner_q == OWN_A) ? a_req : b_req)) begin
          last_d  = owner_q;
          ga_n_d  = 1'b1;
          gb_n_d  = 1'b1;
          cnt_d   = CNT_W'(TURN_CYC - 1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read data is captured on the last ACCESS edge of a read.
  always_comb begin
    load_rd = (state_q == ACCESS) && (cnt_q == '0) && !wr_q;
  end

  shared_ram_port #(.DW(DW)) u_port_a (
    .clk       (clk),
    .reset     (reset),
    .req_i     (a_req),
    .grant_i   (owner_q == OWN_A),
    .release_i (state_q == RELEASE),
    .load_i    (load_rd && (owner_q == OWN_A)),
    .rdata_i   (ram_rdata),
    .dout_o    (a_dout),
    .wait_n_o  (a_wait_n)
  );

  shared_ram_port #(.DW(DW)) u_port_b (
    .clk       (clk),
    .reset     (reset),
    .req_i     (b_req),
    .grant_i   (owner_q == OWN_B),
    .release_i (state_q == RELEASE),
    .load_i    (load_rd && (owner_q == OWN_B)),
    .rdata_i   (ram_rdata),
    .dout_o    (b_dout),
    .wait_n_o  (b_wait_n)
  );

  assign ga_n      = ga_n_q;
  assign gb_n      = gb_n_q;
  assign ram_oe_n  = oe_n_q;
  assign ram_we_n  = we_n_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Directed and random-traffic bench for shared_ram_arbiter at default parameters.
module tb_shared_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_wr, b_req, b_wr;
  logic [10:0] a_addr, b_addr, ram_addr;
  logic [7:0]  a_din, b_din, a_dout, b_dout, ram_wdata, ram_rdata;
  logic        a_wait_n, b_wait_n, ga_n, gb_n, ram_oe_n, ram_we_n;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  shared_ram_arbiter #(.AW(11), .DW(8), .ACCESS_CYC(2), .TURN_CYC(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_req     (a_req),
    .a_wr      (a_wr),
    .a_addr    (a_addr),
    .a_din     (a_din),
    .a_dout    (a_dout),
    .a_wait_n  (a_wait_n),
    .b_req     (b_req),
    .b_wr      (b_wr),
    .b_addr    (b_addr),
    .b_din     (b_din),
    .b_dout    (b_dout),
    .b_wait_n  (b_wait_n),
    .ga_n      (ga_n),
    .gb_n      (gb_n),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_oe_n  (ram_oe_n),
    .ram_we_n  (ram_we_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] fdat(input logic [10:0] ad);
    return ad[7:0] ^ 8'hA5;
  endfunction

  initial begin
    int unsigned we_cyc, oe_cyc, bad, derr, maxw, done, aw, bw;
    bit seen;

    reset = 1'b1; a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_din = '0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_din = '0; ram_rdata = '0;
    repeat (3) step();

    // Reset state
    chk("rst_ga_n", 32'(ga_n), 32'd1);
    chk("rst_gb_n", 32'(gb_n), 32'd1);
    chk("rst_oe_n", 32'(ram_oe_n), 32'd1);
    chk("rst_we_n", 32'(ram_we_n), 32'd1);
    chk("rst_a_dout", 32'(a_dout), 32'h0);
    chk("rst_b_dout", 32'(b_dout), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_a_wait_idle", 32'(a_wait_n), 32'd1);
    a_req = 1'b1; #1;
    chk("rst_a_wait_req", 32'(a_wait_n), 32'd0);
    a_req = 1'b0; #1;
    reset = 1'b0;
    step();

    // Reset during ACCESS of an A read aborts without touching a_dout
    a_req = 1'b1; a_wr = 1'b0; a_addr = 11'h123; ram_rdata = 8'h77;
    step();
    chk("ab_setup_ga_n", 32'(ga_n), 32'd0);
    step();
    chk("ab_access_oe_n", 32'(ram_oe_n), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("ab_async_ga_n", 32'(ga_n), 32'd1);
    chk("ab_async_oe_n", 32'(ram_oe_n), 32'd1);
    a_req = 1'b0;
    step(); step();
    chk("ab_a_dout", 32'(a_dout), 32'h0);
    reset = 1'b0;
    step();

    // Uncontended A read starting from SETUP
    a_req = 1'b1; a_wr = 1'b0; a_addr = 11'h123; ram_rdata = 8'h5A;
    #1;
    chk("ar_wait_c0", 32'(a_wait_n), 32'd0);
    step();
    chk("ar_ga_n_c1", 32'(ga_n), 32'd0);
    chk("ar_oe_n_c1", 32'(ram_oe_n), 32'd1);
    chk("ar_addr_c1", 32'(ram_addr), 32'h123);
    step();
    chk("ar_oe_n_c2", 32'(ram_oe_n), 32'd0);
    chk("ar_we_n_c2", 32'(ram_we_n), 32'd1);
    chk("ar_wait_c2", 32'(a_wait_n), 32'd0);
    step();
    chk("ar_oe_n_c3", 32'(ram_oe_n), 32'd0);
    chk("ar_gb_n_c3", 32'(gb_n), 32'd1);
    step();
    chk("ar_oe_n_c4", 32'(ram_oe_n), 32'd1);
    chk("ar_dout_c4", 32'(a_dout), 32'h5A);
    chk("ar_wait_c4", 32'(a_wait_n), 32'd1);
    chk("ar_ga_n_c4", 32'(ga_n), 32'd0);
    a_req = 1'b0;
    step();
    chk("ar_ga_n_gap", 32'(ga_n), 32'd1);
    chk("ar_gb_n_gap", 32'(gb_n), 32'd1);
    step();

    // Tie after reset: A first, gap, then B; a second tie goes to A
    reset = 1'b1; step(); reset = 1'b0; step();
    a_req = 1'b1; a_wr = 1'b0; a_addr = 11'h010;
    b_req = 1'b1; b_wr = 1'b0; b_addr = 11'h020; ram_rdata = 8'h11;
    step();
    chk("tie1_ga_n", 32'(ga_n), 32'd0);
    chk("tie1_gb_n", 32'(gb_n), 32'd1);
    chk("tie1_addr", 32'(ram_addr), 32'h010);
    step(); step(); step();
    chk("tie1_a_dout", 32'(a_dout), 32'h11);
    chk("tie1_a_wait", 32'(a_wait_n), 32'd1);
    chk("tie1_b_wait", 32'(b_wait_n), 32'd0);
    a_req = 1'b0; ram_rdata = 8'h22;
    step();
    chk("tie_gap_ga_n", 32'(ga_n), 32'd1);
    chk("tie_gap_gb_n", 32'(gb_n), 32'd1);
    step();
    chk("tie_idle_gb_n", 32'(gb_n), 32'd1);
    step();
    chk("tie2_gb_n", 32'(gb_n), 32'd0);
    chk("tie2_ga_n", 32'(ga_n), 32'd1);
    chk("tie2_addr", 32'(ram_addr), 32'h020);
    step(); step(); step();
    chk("tie2_b_dout", 32'(b_dout), 32'h22);
    chk("tie2_b_wait", 32'(b_wait_n), 32'd1);
    chk("tie2_a_dout", 32'(a_dout), 32'h11);
    b_req = 1'b0;
    step(); step();
    a_req = 1'b1; b_req = 1'b1; ram_rdata = 8'h33;
    step();
    chk("tie3_ga_n", 32'(ga_n), 32'd0);
    chk("tie3_gb_n", 32'(gb_n), 32'd1);
    step(); step(); step();
    chk("tie3_a_dout", 32'(a_dout), 32'h33);
    a_req = 1'b0; b_req = 1'b0;
    step(); step();

    // B write leaves b_dout alone
    b_req = 1'b1; b_wr = 1'b1; b_addr = 11'h7FF; b_din = 8'hC3; ram_rdata = 8'hEE;
    we_cyc = 0; oe_cyc = 0; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (!ram_we_n) begin
        we_cyc++;
        chk("bw_addr", 32'(ram_addr), 32'h7FF);
        chk("bw_wdata", 32'(ram_wdata), 32'hC3);
      end
      if (!ram_oe_n) oe_cyc++;
      if (b_wait_n) seen = 1'b1;
    end
    chk("bw_wait_rise", 32'(seen), 32'd1);
    chk("bw_we_cycles", we_cyc, 32'd2);
    chk("bw_oe_cycles", oe_cyc, 32'd0);
    chk("bw_b_dout", 32'(b_dout), 32'h22);
    b_req = 1'b0; b_wr = 1'b0;
    step(); step();
    chk("bw_gb_n_end", 32'(gb_n), 32'd1);

    // Random A/B traffic; RAM returns fdat(address)
    bad = 0; derr = 0; maxw = 0; done = 0; aw = 0; bw = 0;
    for (int c = 0; c < 10000; c++) begin
      step();
      ram_rdata = fdat(ram_addr);
      if ((!ga_n && !gb_n) || (!ram_oe_n && !ram_we_n) ||
          ((!ram_oe_n || !ram_we_n) && ga_n && gb_n)) bad++;
      if (a_req && a_wait_n) begin
        if (!a_wr && a_dout !== fdat(a_addr)) derr++;
        done++; a_req = 1'b0; aw = 0;
      end else if (a_req) begin
        aw++;
        if (aw > maxw) maxw = aw;
      end else if ($urandom_range(3) == 0) begin
        a_wr = 1'($urandom_range(1)); a_addr = 11'($urandom); a_din = 8'($urandom);
        a_req = 1'b1;
      end
      if (b_req && b_wait_n) begin
        if (!b_wr && b_dout !== fdat(b_addr)) derr++;
        done++; b_req = 1'b0; bw = 0;
      end else if (b_req) begin
        bw++;
        if (bw > maxw) maxw = bw;
      end else if ($urandom_range(3) == 0) begin
        b_wr = 1'($urandom_range(1)); b_addr = 11'($urandom); b_din = 8'($urandom);
        b_req = 1'b1;
      end
    end
    chk("rand_bus_conflicts", bad, 32'd0);
    chk("rand_read_data", derr, 32'd0);
    chk("rand_wait_bounded", 32'(maxw <= 30), 32'd1);
    chk("rand_progress", 32'(done >= 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shared_ram_arbiter.md
# shared_ram_arbiter

Two-port arbiter sitting directly upstream of the 74244 tri-state buffer pair that isolates the shared work RAM from the main and sub Z80 buses. It grants the RAM to one CPU at a time and drives the active-low buffer enables. It sequences RAM read and write strobes, latches read data for the owning CPU, and stretches each CPU cycle through its WAIT line. A guaranteed dead gap between owners means the two buffer banks are never enabled together.

## Interface
- AW, 11: RAM address width.
- DW, 8: data width.
- ACCESS_CYC, 2: cycles the RAM strobe is held low; legal range 1..15.
- TURN_CYC, 1: cycles with both enables high between owners; legal range 1..15.

- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- a_req  in  1  port A access request (decoded MREQ and chip select), active-high.
- a_wr  in  1  port A direction: 1 = write, 0 = read; stable while a_req is high.
- a_addr  in  AW  port A address.
- a_din  in  DW  port A write data.
- a_dout  out  DW  port A latched read data.
- a_wait_n  out  1  port A WAIT, active-low.
- b_req, b_wr, b_addr, b_din, b_dout, b_wait_n: port B, same as port A.
- ga_n  out  1  enable for the port A 74244 bank, active-low.
- gb_n  out  1  enable for the port B 74244 bank, active-low.
- ram_addr  out  AW  registered address of the current owner.
- ram_wdata  out  DW  registered write data of the current owner.
- ram_rdata  in  DW  RAM read data.
- ram_oe_n  out  1  RAM output enable, active-low.
- ram_we_n  out  1  RAM write enable, active-low.

## Operation
- States: IDLE, SETUP, ACCESS, RELEASE, GAP. The owner register holds A or B.
- IDLE
  - With no request, stay in IDLE.
  - With one request, that port becomes owner and the FSM goes to SETUP.
  - With both requests, the port that is not last_owner wins. last_owner resets to B, so A wins the first tie.
- SETUP (1 cycle)
  - Owner's enable goes low.
  - ram_addr and ram_wdata are captured from the owner.
  - Both strobes stay high.
- ACCESS (ACCESS_CYC cycles, counted by the access counter)
  - ram_oe_n is low for a read; ram_we_n is low for a write.
  - On the final ACCESS edge, a read copies ram_rdata into the owner's dout, and both strobes are driven high.
- RELEASE
  - Owner's wait_n is high and its enable stays low.
  - The FSM leaves for GAP on the first edge where the owner's req is sampled low, and updates last_owner.
- GAP (TURN_CYC cycles)
  - Both enables and both strobes are high, then the FSM returns to IDLE.
- wait_n is combinational: x_wait_n = !(x_req && !(owner==x && state==RELEASE)). WAIT therefore asserts in the same cycle the request rises.
- A non-owner request stays waited until it is granted.
- ga_n and gb_n are registered and are never both low. A one-hot owner decode guarantees this.
- If the owner drops req during SETUP or ACCESS, the access still completes and the FSM passes through RELEASE for one cycle into GAP.
- x_dout holds its value until the next read by that port; writes do not change it.

## Timing
- Reset values:
  - state IDLE, last_owner B.
  - ga_n, gb_n, ram_oe_n, ram_we_n = 1.
  - ram_addr, ram_wdata, a_dout, b_dout = 0.
  - wait_n = !req.
- Reset asserted mid-access aborts immediately: enables and strobes go high asynchronously and no dout is updated.
- Uncontended latency: req is sampled at edge E0. SETUP follows E0, ACCESS follows E1, and RELEASE follows E(1+ACCESS_CYC). wait_n rises 2+ACCESS_CYC cycles after E0 (4 at defaults).
- Back-to-back owners: the earliest grant to the other port is 1+TURN_CYC cycles after the RELEASE exit edge.
- Widths: the access and gap counters are 4 bits. There is no arithmetic on data or addresses.

## Structure
- Package shared_ram_arbiter_pkg holds:
  - state enum {IDLE, SETUP, ACCESS, RELEASE, GAP};
  - owner encoding (OWN_A = 0, OWN_B = 1);
  - the 4-bit counter width constant.
- Sub-module shared_ram_port, instantiated twice, contains the per-port dout latch and the wait_n generation. Its inputs are req, grant, release and load.
- The FSM, counters and enable/strobe registers live in the top module.

## Test plan
- Reset then idle: all enables and strobes are 1, douts are 0; a_req=0 gives a_wait_n=1.
- Port A read, addr 0x123, ram_rdata 0x5A: ga_n low from cycle 1; ram_oe_n low for 2 cycles; a_dout=0x5A and a_wait_n=1 at cycle 4; gb_n stays 1 throughout.
- Simultaneous a_req and b_req after reset: A is served first, then a 1-cycle gap with ga_n=gb_n=1, then B. A second tie goes to A again because last_owner is now B.
- Port B write, addr 0x7FF, data 0xC3: ram_we_n low for exactly 2 cycles with ram_addr=0x7FF and ram_wdata=0xC3; b_dout is unchanged.
- Reset asserted during ACCESS of an A read: ga_n and ram_oe_n go to 1 without waiting for a clock edge; a_dout keeps its previous value; the next request starts from SETUP.
- Randomized A/B traffic for 10k cycles: ga_n and gb_n are never both 0; no strobe is low outside ACCESS; every granted request eventually sees wait_n rise.
